accumulator_bank: RTL and testbench

// - Downstream of the 16-lane parallel adder stage: accumulates each lane's signed sum over a programmed number of input beats.
// - Emits one saturated, scaled result vector per accumulation window over a valid/ready handshake.
// - Turns per-cycle partial sums into finished outputs, e.g. a convolution channel sum.

---
 rtl/accumulator_bank_pkg.sv | 36 +++
 rtl/accumulator_bank_if.sv | 34 +++
 rtl/accumulator_bank_lane.sv | 50 +++++
 rtl/accumulator_bank.sv | 131 +++++++++++++
 tb/tb_accumulator_bank.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/accumulator_bank_pkg.sv
// Shared definitions for the accumulator bank.
// Contents:
//   accum_state_t - control FSM encoding (IDLE, ACCUM, OUTPUT)
//   SAT_MAX_W     - working width of the saturation helper
//   saturate()    - clamps a wide signed value into an out_w-bit signed range
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } accum_state_t;

    // Every lane value is widened to this many bits before clamping, so one
    // helper serves any ACC_WIDTH/OUT_WIDTH combination up to 64 bits.
    localparam int unsigned SAT_MAX_W = 64;

    // Clamp val into [-2^(out_w-1), 2^(out_w-1)-1]; the caller keeps the low out_w bits.
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input logic signed [SAT_MAX_W-1:0] val,
        input int unsigned                 out_w
    );
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (val > max_v) begin
            saturate = max_v;
        end else if (val < min_v) begin
            saturate = min_v;
        end else begin
            saturate = val;
        end
    endfunction

endpackage

// File: rtl/accumulator_bank_if.sv
// Handshake/bus bundle for the accumulator bank.
// Signals:
//   start, cfg_len          - window request and its beat count
//   in_valid/in_ready/in_data    - input beat handshake, LANES packed signed lanes
//   out_valid/out_ready/out_data - result handshake, LANES packed signed lanes
//   busy, done              - status: not idle / one-cycle acceptance pulse
// Modports: master = producer/consumer side (testbench), slave = the bank.
interface accumulator_bank_if #(
    parameter int LANES     = 16,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) ();
    logic                       start;
    logic [CNT_WIDTH-1:0]       cfg_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*IN_WIDTH-1:0]  in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*OUT_WIDTH-1:0] out_data;
    logic                       busy;
    logic                       done;

    modport master (
        output start, cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/accumulator_bank_lane.sv
// accum_lane: one lane of the accumulator bank.
// Holds a wrapping signed accumulator; the output is the accumulator shifted
// right arithmetically by OUT_SCALE and saturated to OUT_WIDTH bits.
// Ports:
//   clk, arst_n_in - clock, asynchronous active-low reset
//   clr            - zero the accumulator (window start); has priority over en
//   en             - add in_val into the accumulator this cycle
//   in_val         - signed lane input
//   out_val        - signed saturated, scaled result (combinational from acc)
module accum_lane
    import accum_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SCALE = 0
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  in_val,
    output logic signed [OUT_WIDTH-1:0] out_val
);
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] in_ext_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic signed [SAT_MAX_W-1:0] wide_s;
    logic signed [SAT_MAX_W-1:0] sat_s;

    // Signed casts sign-extend, so this also works when ACC_WIDTH == IN_WIDTH.
    assign in_ext_s  = ACC_WIDTH'(in_val);
    assign shifted_s = acc_r >>> OUT_SCALE;
    assign wide_s    = SAT_MAX_W'(shifted_s);
    assign sat_s     = saturate(wide_s, OUT_WIDTH);
    assign out_val   = sat_s[OUT_WIDTH-1:0];

    // Accumulator: cleared at window start, wraps modulo 2^ACC_WIDTH on each beat.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + in_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: accumulates LANES signed lane sums over a programmed
// number of input beats and presents one saturated, scaled result vector per
// window over a valid/ready handshake.
// Ports:
//   clk, arst_n_in - clock, asynchronous active-low reset
//   bus (slave)    - start/cfg_len, input beat handshake, output handshake,
//                    busy and done status (see accumulator_bank_if)
// in_ready, out_valid and busy decode the state register only; done is a flop.
module accumulator_bank
    import accum_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SCALE = 0,
    parameter int CNT_WIDTH = 8
) (
    input logic               clk,
    input logic               arst_n_in,
    accumulator_bank_if.slave bus
);
    accum_state_t           state_r;
    accum_state_t           next_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   len_r;
    logic [CNT_WIDTH:0]     cnt_inc_s;
    logic                   done_r;
    logic                   accept_start_s;
    logic                   beat_s;
    logic                   last_beat_s;
    logic                   out_fire_s;
    logic [LANES*OUT_WIDTH-1:0] out_bus_s;

    assign accept_start_s = (state_r == IDLE) && bus.start;
    assign beat_s         = (state_r == ACCUM) && bus.in_valid;
    // One extra bit so cfg_len = 2^CNT_WIDTH-1 compares without wrapping.
    assign cnt_inc_s      = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign last_beat_s    = beat_s && (cnt_inc_s == {1'b0, len_r});
    assign out_fire_s     = (state_r == OUTPUT) && bus.out_ready;

    assign bus.in_ready  = (state_r == ACCUM);
    assign bus.out_valid = (state_r == OUTPUT);
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
    assign bus.out_data  = out_bus_s;

    // State register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_s = ACCUM;
                end else begin
                    next_s = IDLE;
                end
            end
            ACCUM: begin
                if (last_beat_s) begin
                    next_s = OUTPUT;
                end else begin
                    next_s = ACCUM;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = OUTPUT;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Beat counter and latched window length; a zero length runs one beat.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            cnt_r <= '0;
            len_r <= '0;
        end else if (accept_start_s) begin
            cnt_r <= '0;
            if (bus.cfg_len == {CNT_WIDTH{1'b0}}) begin
                len_r <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                len_r <= bus.cfg_len;
            end
        end else if (beat_s) begin
            cnt_r <= cnt_inc_s[CNT_WIDTH-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // done pulses for the single cycle following output acceptance.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            done_r <= 1'b0;
        end else begin
            done_r <= out_fire_s;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        accum_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .OUT_SCALE (OUT_SCALE)
        ) u_lane (
            .clk       (clk),
            .arst_n_in (arst_n_in),
            .clr       (accept_start_s),
            .en        (beat_s),
            .in_val    (bus.in_data[i*IN_WIDTH +: IN_WIDTH]),
            .out_val   (out_bus_s[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end
endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;
    localparam int LANES = 16;

    logic clk;
    logic arst_n;
    int   checks;
    int   failures;
    logic [255:0] exp_q[$];

    accumulator_bank_if #(.LANES(16), .IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(8)) if0 ();
    accumulator_bank_if #(.LANES(16), .IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(8)) if2 ();

    accumulator_bank #(.LANES(16), .IN_WIDTH(16), .ACC_WIDTH(32), .OUT_WIDTH(16),
                       .OUT_SCALE(0), .CNT_WIDTH(8))
        dut (.clk(clk), .arst_n_in(arst_n), .bus(if0.slave));

    accumulator_bank #(.LANES(16), .IN_WIDTH(16), .ACC_WIDTH(32), .OUT_WIDTH(16),
                       .OUT_SCALE(2), .CNT_WIDTH(8))
        dut2 (.clk(clk), .arst_n_in(arst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]         cfg;
        int                 nbeats;
        logic signed [15:0] beats [4];
        bit                 mul;   // lane i sees beat*(i+1) and expects exp*(i+1)
        logic signed [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [255:0] lanes(input logic signed [15:0] v, input bit mul);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*16 +: 16] = mul ? 16'(v * (i + 1)) : v;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_window(input logic [7:0] cfg, input logic [255:0] expv);
        exp_q.push_back(expv);
        if0.start   = 1'b1;
        if0.cfg_len = cfg;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    // Called at a negedge; presents one (possibly invalid) beat for a cycle.
    task automatic beat(input logic signed [15:0] v, input bit mul, input bit valid);
        if0.in_valid = valid;
        if0.in_data  = lanes(v, mul);
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        if0.in_data  = '0;
    endtask

    // Called at the negedge right after the final beat.
    task automatic finish_window(input string tag, input int bp_cycles);
        logic [255:0] held;
        logic [255:0] expv;
        check({tag, "_out_valid_lat"}, 256'(if0.out_valid), 256'd1);
        check({tag, "_in_ready_low"},  256'(if0.in_ready),  256'd0);
        held = if0.out_data;
        for (int k = 0; k < bp_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bp_stable"}, if0.out_data, held);
            check({tag, "_bp_no_done"}, {254'd0, if0.done, if0.out_valid}, 256'd1);
        end
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 256'd0, 256'd1);
        end else begin
            expv = exp_q.pop_front();
            check({tag, "_out_data"}, if0.out_data, expv);
        end
        if0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.out_ready = 1'b0;
        check({tag, "_done_pulse"}, {253'd0, if0.done, if0.busy, if0.out_valid}, 256'd4);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_clear"}, 256'(if0.done), 256'd0);
    endtask

    vec_t vecs [7];

    initial begin
        checks   = 0;
        failures = 0;
        arst_n   = 1'b0;
        if0.start = 1'b0; if0.cfg_len = '0; if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        if2.start = 1'b0; if2.cfg_len = '0; if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;

        vecs[0] = '{8'd4, 4, '{16'sd1, 16'sd1, 16'sd1, 16'sd1}, 1'b1, 16'sd4};
        vecs[1] = '{8'd4, 4, '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF}, 1'b0, 16'sh7FFF};
        vecs[2] = '{8'd4, 4, '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000}, 1'b0, 16'sh8000};
        vecs[3] = '{8'd4, 4, '{16'sd100, 16'sd100, 16'sd100, -16'sd500}, 1'b0, -16'sd200};
        vecs[4] = '{8'd0, 1, '{16'sd9, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 16'sd9};
        vecs[5] = '{8'd2, 2, '{16'sd500, -16'sd1500, 16'sd0, 16'sd0}, 1'b1, -16'sd1000};
        vecs[6] = '{8'd3, 3, '{16'sd20000, 16'sd20000, -16'sd30000, 16'sd0}, 1'b0, 16'sd10000};

        @(negedge clk);
        check("reset_ctrl", {252'd0, if0.in_ready, if0.out_valid, if0.busy, if0.done}, 256'd0);
        check("reset_data", if0.out_data, 256'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("idle_in_valid_ignored", {255'd0, if0.in_ready}, 256'd0);

        // Table-driven windows.
        for (int v = 0; v < 7; v++) begin
            start_window(vecs[v].cfg, lanes(vecs[v].exp, vecs[v].mul));
            check($sformatf("vec%0d_busy", v), 256'(if0.busy), 256'd1);
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                check($sformatf("vec%0d_in_ready", v), 256'(if0.in_ready), 256'd1);
                beat(vecs[v].beats[b], vecs[v].mul, 1'b1);
            end
            finish_window($sformatf("vec%0d", v), 0);
        end

        // Stalls: in_valid 1,0,0,1,0,1 with 7 on every lane.
        start_window(8'd3, lanes(16'sd21, 1'b0));
        beat(16'sd7, 1'b0, 1'b1);
        beat(16'sd7, 1'b0, 1'b0);
        beat(16'sd7, 1'b0, 1'b0);
        beat(16'sd7, 1'b0, 1'b1);
        beat(16'sd7, 1'b0, 1'b0);
        check("stall_not_early", 256'(if0.out_valid), 256'd0);
        beat(16'sd7, 1'b0, 1'b1);
        finish_window("stall", 0);

        // Back-pressure plus a start pulse during ACCUM that must be ignored.
        start_window(8'd2, lanes(16'sd33, 1'b1));
        beat(16'sd11, 1'b1, 1'b1);
        if0.start   = 1'b1;
        if0.cfg_len = 8'd5;
        beat(16'sd22, 1'b1, 1'b1);
        if0.start = 1'b0;
        finish_window("bp", 5);

        // Maximum length: 255 beats without counter wrap.
        start_window(8'd255, lanes(16'sd25500, 1'b0));
        for (int k = 0; k < 255; k++) begin
            if (k == 254) begin
                check("len255_before_last", {254'd0, if0.in_ready, if0.out_valid}, 256'd2);
            end
            beat(16'sd100, 1'b0, 1'b1);
        end
        finish_window("len255", 0);

        // Reset mid-window discards the partial sum.
        start_window(8'd4, lanes(16'sd0, 1'b0));
        beat(16'sd3, 1'b0, 1'b1);
        beat(16'sd3, 1'b0, 1'b1);
        arst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("midrst_ctrl", {252'd0, if0.in_ready, if0.out_valid, if0.busy, if0.done}, 256'd0);
        check("midrst_data", if0.out_data, 256'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        start_window(8'd1, lanes(16'sd5, 1'b0));
        beat(16'sd5, 1'b0, 1'b1);
        finish_window("post_rst", 0);

        // OUT_SCALE=2 instance: -7 + -6 = -13, >>> 2 = -4.
        if2.start   = 1'b1;
        if2.cfg_len = 8'd2;
        @(posedge clk); @(negedge clk);
        if2.start    = 1'b0;
        if2.in_valid = 1'b1;
        if2.in_data  = lanes(-16'sd7, 1'b0);
        @(posedge clk); @(negedge clk);
        if2.in_data  = lanes(-16'sd6, 1'b0);
        @(posedge clk); @(negedge clk);
        if2.in_valid = 1'b0;
        check("scale2_valid", 256'(if2.out_valid), 256'd1);
        check("scale2_data", if2.out_data, lanes(-16'sd4, 1'b0));
        if2.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if2.out_ready = 1'b0;
        check("scale2_done", 256'(if2.done), 256'd1);

        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
